// File: rtl/dmem_lsu.sv
// Load/store unit between a CPU request port and a single-port-style data memory
// with combinational read. Optional misalignment trap: DMEM_LSU_MISALIGN_TRAP_EN.
module dmem_lsu #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              dmem_wen,
  output logic [ADDR_W-1:0] dmem_waddr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic              dmem_ren,
  output logic [ADDR_W-1:0] dmem_raddr,
  input  logic [DATA_W-1:0] dmem_rdata
);

  localparam int NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t              state_q;
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W+1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                req_ready_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                dmem_wen_q;
  logic [ADDR_W-1:0]   dmem_waddr_q;
  logic [DATA_W-1:0]   dmem_wdata_q;
  logic                dmem_ren_q;
  logic [ADDR_W-1:0]   dmem_raddr_q;

  logic                trap_w;
  logic [NB-1:0]       be_d;
  logic [DATA_W-1:0]   repl_d;
  logic [DATA_W-1:0]   merge_d;
  logic [DATA_W-1:0]   load_d;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;

  // Store data replicated across all lanes; the byte enables pick the target lane.
  always_comb begin
    be_d   = '1;
    repl_d = wdata_q;
    if (size_q == 2'b00) begin
      be_d   = NB'(1) << addr_q[1:0];
      repl_d = {NB{wdata_q[7:0]}};
    end else if (size_q == 2'b01) begin
      be_d   = NB'(4'b0011) << {addr_q[1], 1'b0};
      repl_d = {(NB/2){wdata_q[15:0]}};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      assign merge_d[8*gi +: 8] = be_d[gi] ? repl_d[8*gi +: 8] : dmem_rdata[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    lane_b = dmem_rdata[8*addr_q[1:0] +: 8];
    lane_h = dmem_rdata[16*addr_q[1] +: 16];
    case (size_q)
      2'b00:   load_d = {{(DATA_W-8){~uns_q & lane_b[7]}}, lane_b};
      2'b01:   load_d = {{(DATA_W-16){~uns_q & lane_h[15]}}, lane_h};
      default: load_d = dmem_rdata;
    endcase
  end

`ifdef DMEM_LSU_MISALIGN_TRAP_EN
  logic rsp_err_q;

  assign trap_w = (req_size == 2'b11) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                  (req_size == 2'b01 && req_addr[0]);

  always_ff @(posedge clk) begin
    if (rst || (state_q == RSP && rsp_ready)) begin
      rsp_err_q <= 1'b0;
    end else if (state_q == IDLE && req_valid) begin
      rsp_err_q <= trap_w;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign trap_w  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      dmem_wen_q   <= 1'b0;
      dmem_waddr_q <= '0;
      dmem_wdata_q <= '0;
      dmem_ren_q   <= 1'b0;
      dmem_raddr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            if (trap_w) begin
              state_q     <= RSP;
              rsp_valid_q <= 1'b1;
              rsp_rdata_q <= '0;
            end else if (req_we && req_size[1]) begin
              // Full-word store needs no read of the old contents.
              state_q      <= WR;
              dmem_wen_q   <= 1'b1;
              dmem_waddr_q <= req_addr[ADDR_W+1:2];
              dmem_wdata_q <= req_wdata;
            end else begin
              state_q      <= RD;
              dmem_ren_q   <= 1'b1;
              dmem_raddr_q <= req_addr[ADDR_W+1:2];
            end
          end
        end
        RD: begin
          dmem_ren_q   <= 1'b0;
          dmem_raddr_q <= '0;
          if (we_q) begin
            state_q      <= WR;
            dmem_wen_q   <= 1'b1;
            dmem_waddr_q <= addr_q[ADDR_W+1:2];
            dmem_wdata_q <= merge_d;
          end else begin
            state_q     <= RSP;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= load_d;
          end
        end
        WR: begin
          dmem_wen_q   <= 1'b0;
          dmem_waddr_q <= '0;
          dmem_wdata_q <= '0;
          state_q      <= RSP;
          rsp_valid_q  <= 1'b1;
          rsp_rdata_q  <= '0;
        end
        RSP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            req_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign dmem_wen   = dmem_wen_q;
  assign dmem_waddr = dmem_waddr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_ren   = dmem_ren_q;
  assign dmem_raddr = dmem_raddr_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a combinational-read memory model.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [13:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        dmem_wen;
  logic [11:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic        dmem_ren;
  logic [11:0] dmem_raddr;
  logic [31:0] dmem_rdata;

  logic [31:0] mem [0:4095];

  int tests = 0;
  int fails = 0;
  int overlap_n = 0;
  int stray_n = 0;
  int wen_total = 0;

  int          lat, rd_n, wr_n, rd_at, wr_at;
  logic [31:0] r_data, w_data;
  logic [11:0] r_addr, w_addr;
  logic        r_err;

  always #5 clk = ~clk;

  dmem_lsu #(.ADDR_W(12), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .dmem_wen(dmem_wen), .dmem_waddr(dmem_waddr), .dmem_wdata(dmem_wdata),
    .dmem_ren(dmem_ren), .dmem_raddr(dmem_raddr), .dmem_rdata(dmem_rdata)
  );

  assign dmem_rdata = mem[dmem_raddr];

  always @(posedge clk) begin
    if (dmem_wen) mem[dmem_waddr] <= dmem_wdata;
  end

  always @(negedge clk) begin
    if (dmem_ren && dmem_wen) overlap_n++;
    if (!dmem_wen && (dmem_waddr != 0 || dmem_wdata != 0)) stray_n++;
    if (!dmem_ren && dmem_raddr != 0) stray_n++;
    if (dmem_wen) wen_total++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_dmem_bus"}, {dmem_wen, dmem_ren, dmem_waddr, dmem_raddr, dmem_wdata}, 0);
  endtask

  task automatic send(input logic we, input logic [1:0] size, input logic uns,
                      input logic [13:0] addr, input logic [31:0] wd);
    @(negedge clk);
    chk("req_ready_before_accept", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [13:0] addr, input logic [31:0] wd);
    send(we, size, uns, addr, wd);
    lat = 0; rd_n = 0; wr_n = 0; rd_at = 0; wr_at = 0;
    r_data = '0; w_data = '0; r_addr = '0; w_addr = '0; r_err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (dmem_ren) begin rd_n++; rd_at = k; r_addr = dmem_raddr; end
      if (dmem_wen) begin wr_n++; wr_at = k; w_addr = dmem_waddr; w_data = dmem_wdata; end
      if (rsp_valid) begin lat = k; r_data = rsp_rdata; r_err = rsp_err; break; end
    end
    @(posedge clk);
    #1;
    $display("[TB] txn we=%0d size=%0d uns=%0d addr=0x%03h wd=0x%08h -> lat=%0d rdata=0x%08h err=%0d rd=%0d wr=%0d",
             we, size, uns, addr, wd, lat, r_data, r_err, rd_n, wr_n);
  endtask

  initial begin
    int stall_lat;
    int wen_before;
    for (int i = 0; i < 4096; i++) mem[i] = '0;

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");

    // Word store then word load at byte address 0x010 (word 4)
    access(1'b1, 2'b10, 1'b0, 14'h010, 32'hDEADBEEF);
    chk("wst_lat", lat, 2);
    chk("wst_wen_pulses", wr_n, 1);
    chk("wst_wr_cycle", wr_at, 1);
    chk("wst_waddr", w_addr, 12'h004);
    chk("wst_wdata", w_data, 32'hDEADBEEF);
    chk("wst_no_read", rd_n, 0);
    chk("wst_rdata_zero", r_data, 0);
    chk("wst_mem", mem[4], 32'hDEADBEEF);

    access(1'b0, 2'b10, 1'b0, 14'h010, 32'h0);
    chk("wld_lat", lat, 2);
    chk("wld_rd_cycle", rd_at, 1);
    chk("wld_raddr", r_addr, 12'h004);
    chk("wld_rdata", r_data, 32'hDEADBEEF);
    chk("wld_no_write", wr_n, 0);

    // Byte store through read-modify-write
    mem[4] = 32'h11223344;
    access(1'b1, 2'b00, 1'b0, 14'h012, 32'h000000AA);
    chk("bst_rd_cycle", rd_at, 1);
    chk("bst_wr_cycle", wr_at, 2);
    chk("bst_wdata", w_data, 32'h11AA3344);
    chk("bst_lat", lat, 3);
    chk("bst_mem", mem[4], 32'h11AA3344);

    // Half store into the low half
    mem[4] = 32'h80F07F01;
    access(1'b1, 2'b01, 1'b0, 14'h010, 32'hFFFF1234);
    chk("hst_wdata", w_data, 32'h80F01234);
    chk("hst_lat", lat, 3);

    // Sign and zero extension
    mem[4] = 32'h80F07F01;
    access(1'b0, 2'b00, 1'b0, 14'h011, 32'h0);
    chk("lb_signed_pos", r_data, 32'h0000007F);
    access(1'b0, 2'b00, 1'b0, 14'h013, 32'h0);
    chk("lb_signed_neg", r_data, 32'hFFFFFF80);
    access(1'b0, 2'b00, 1'b1, 14'h013, 32'h0);
    chk("lb_unsigned", r_data, 32'h00000080);
    access(1'b0, 2'b01, 1'b0, 14'h012, 32'h0);
    chk("lh_signed", r_data, 32'hFFFF80F0);
    access(1'b0, 2'b01, 1'b1, 14'h012, 32'h0);
    chk("lh_unsigned", r_data, 32'h000080F0);
    access(1'b0, 2'b01, 1'b0, 14'h010, 32'h0);
    chk("lh_signed_low", r_data, 32'h00007F01);

    // Top word index: no wrap into word 0
    mem[0] = 32'h01020304;
    access(1'b1, 2'b10, 1'b0, 14'h3FFC, 32'hA5A5C3C3);
    chk("top_waddr", w_addr, 12'hFFF);
    chk("top_mem", mem[4095], 32'hA5A5C3C3);
    access(1'b1, 2'b00, 1'b0, 14'h3FFF, 32'h0000005A);
    chk("top_byte_mem", mem[4095], 32'h5AA5C3C3);
    chk("top_word0_untouched", mem[0], 32'h01020304);

    // Response back-pressure
    mem[4] = 32'hCAFEF00D;
    rsp_ready = 1'b0;
    send(1'b0, 2'b10, 1'b0, 14'h010, 32'h0);
    stall_lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin stall_lat = k; break; end
    end
    chk("stall_lat", stall_lat, 2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_rdata", rsp_rdata, 32'hCAFEF00D);
      chk("stall_req_ready", req_ready, 0);
    end
    $display("[TB] txn stalled load 0x010 held rdata=0x%08h for 5 cycles", rsp_rdata);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 14'h010;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_valid", rsp_valid, 0);
    chk("post_hs_ready", req_ready, 1);
    chk("post_hs_no_read", dmem_ren, 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("accept_next_ren", dmem_ren, 1);
    chk("accept_next_busy", req_ready, 0);
    @(negedge clk);
    chk("accept_next_valid", rsp_valid, 1);
    chk("accept_next_rdata", rsp_rdata, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    $display("[TB] txn back-to-back load 0x010 after handshake");

    // Reset during the WR cycle of a byte store
    mem[4] = 32'h11223344;
    send(1'b1, 2'b00, 1'b0, 14'h010, 32'h00000055);
    @(negedge clk);
    @(negedge clk);
    chk("rstwr_in_wr", dmem_wen, 1);
    chk("rstwr_wdata", dmem_wdata, 32'h11223355);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk_idle_outputs("rst_in_wr");
    $display("[TB] txn byte store 0x010 aborted by reset in WR");

    // Reset during the RD cycle of a byte store: no write may follow
    mem[4] = 32'h11223344;
    wen_before = wen_total;
    send(1'b1, 2'b00, 1'b0, 14'h010, 32'h00000055);
    @(negedge clk);
    chk("rstrd_in_rd", dmem_ren, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk_idle_outputs("rst_in_rd");
    repeat (3) @(negedge clk);
    chk("rstrd_mem_unchanged", mem[4], 32'h11223344);
    chk("rstrd_no_write", wen_total - wen_before, 0);
    $display("[TB] txn byte store 0x010 aborted by reset in RD");

    // Misaligned word load
    mem[4] = 32'h80F07F01;
`ifdef DMEM_LSU_MISALIGN_TRAP_EN
    access(1'b0, 2'b10, 1'b0, 14'h013, 32'h0);
    chk("mis_lat", lat, 1);
    chk("mis_err", r_err, 1);
    chk("mis_rdata", r_data, 0);
    chk("mis_no_strobe", rd_n + wr_n, 0);
    access(1'b1, 2'b11, 1'b0, 14'h010, 32'h12345678);
    chk("ill_err", r_err, 1);
    chk("ill_no_strobe", rd_n + wr_n, 0);
    chk("ill_mem_unchanged", mem[4], 32'h80F07F01);
    access(1'b0, 2'b10, 1'b0, 14'h010, 32'h0);
    chk("aligned_err_clear", r_err, 0);
`else
    access(1'b0, 2'b10, 1'b0, 14'h013, 32'h0);
    chk("mis_lat", lat, 2);
    chk("mis_err", r_err, 0);
    chk("mis_raddr", r_addr, 12'h004);
    chk("mis_rdata", r_data, 32'h80F07F01);
    access(1'b1, 2'b11, 1'b0, 14'h010, 32'h12345678);
    chk("ill_as_word_lat", lat, 2);
    chk("ill_as_word_mem", mem[4], 32'h12345678);
`endif

    chk("no_ren_wen_overlap", overlap_n, 0);
    chk("bus_zero_when_idle", stray_n, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
